er_sched: RTL and testbench
===========================

Name: er_sched

Overview:
Frame-synchronised scheduler for the Earthrise drawing engine. It accepts drawing-list requests from the CPU over a valid/ready handshake. It holds each request until the next frame-start pulse, then issues a single-cycle er_start with the list address and monitors the engine until er_done. It supports one-shot and continuous (redraw every frame) modes and reports completions, overruns and timeouts. It replaces the free-running start logic at the top level; it sits in the clk_sys domain between CPU registers and the Earthrise engine.

Parameters:
ADDRW, 10, drawing-list start address width (bits)
CNTW, 16, status counter width (bits)
TIMEOUT, 2000000, max clk_sys cycles from er_start to er_done before abort (>=2)

Ports:
clk_sys  in  1  system clock
rst_sys  in  1  synchronous reset, active high
frame  in  1  frame-start pulse, already in clk_sys domain, 1 cycle
cmd_valid  in  1  request valid
cmd_ready  out  1  scheduler can accept request
cmd_addr  in  ADDRW  drawing-list start address
cmd_cont  in  1  1=continuous redraw each frame, 0=one-shot
cmd_stop  in  1  1-cycle pulse: end continuous mode after current run
er_start  out  1  1-cycle start pulse to engine
er_addr  out  ADDRW  list address to engine, stable from er_start until done
er_busy  in  1  engine running
er_done  in  1  engine finished, 1-cycle pulse
sts_busy  out  1  state != IDLE
sts_runs  out  CNTW  completed runs (er_done received)
sts_overrun  out  CNTW  frame pulses seen while in RUN
sts_timeout  out  1  sticky: a run exceeded TIMEOUT

Behaviour:
- Reset (synchronous, dominant over all inputs): state=IDLE; er_start=0, er_addr=0, cmd_ready=1 (combinational from IDLE), sts_runs=0, sts_overrun=0, sts_timeout=0, cont flag=0, timeout counter=0. Reset mid-run drops tracking immediately; no er_start is issued in the reset cycle or the cycle after.
- cmd_ready=1 only in IDLE. Transfer occurs on cmd_valid&&cmd_ready; latch cmd_addr into er_addr and cmd_cont into cont; go to ARMED.
- States:
  - IDLE: wait for transfer.
  - ARMED: wait for frame. On frame go to START. A frame in the same cycle as the transfer does not count; the request waits for the next frame.
  - START: er_start=1 for exactly this cycle; timeout counter cleared; go to RUN. Latency frame->er_start = 1 cycle.
  - RUN: count cycles.
    - On er_done: sts_runs+=1. If cont && no stop pending, go to ARMED; otherwise go to IDLE and clear cont.
    - If the count reaches TIMEOUT-1 without er_done: set sts_timeout, go to IDLE, clear cont, sts_runs unchanged.
    - If er_done and the timeout both occur in the same cycle, er_done wins.
    - A frame in RUN increments sts_overrun. If er_done arrives in the same cycle as that frame, the frame still counts as overrun, and the next start waits for the following frame.
- cmd_stop: in ARMED with cont=1, go to IDLE at once with no start. In START/RUN, set stop-pending; it is cleared on exit to IDLE. In IDLE, ignored.
- er_busy is informational only: er_done alone ends a run. er_done outside RUN is ignored.
- Counters saturate at all-ones (no wrap). sts_timeout clears only on reset.
- er_addr changes only on an accepted transfer.

Test Plan:
- Reset, cmd_addr=0x040, cmd_cont=0, valid 1 cycle; frame at cycle 10 -> er_start high exactly at cycle 11, er_addr=0x040; er_done at 50 -> sts_runs=1, IDLE, cmd_ready=1 at 51.
- Continuous: cmd_cont=1, 4 frames, each run done within 100 cycles -> 4 er_start pulses, one per frame, sts_runs=4; cmd_stop mid-run 4 -> IDLE after er_done, no 5th start.
- Overrun: cont, engine takes 1.5 frames -> sts_overrun increments once per late run, next er_start aligned to the following frame; same-cycle er_done+frame also counts as overrun.
- Timeout: TIMEOUT=64, no er_done -> at 64 cycles after er_start: sts_timeout=1, IDLE, sts_runs unchanged; a later er_done is ignored.
- Boundaries: frame coincident with transfer -> no start until next frame; cmd_stop in ARMED -> IDLE, no start; cmd_valid while not ready -> ignored, er_addr unchanged.
- Reset asserted during RUN -> all outputs at reset values next cycle; a new request works normally afterwards; sts_runs saturates at 0xFFFF (bench with CNTW=4 -> holds at 15).

Source files
------------

// File: rtl/er_sched.sv
// Frame-synchronised start scheduler for the Earthrise drawing engine.
// Holds a CPU drawing-list request until the next frame pulse, issues a
// one-cycle start, then tracks the run until done or timeout.
module er_sched #(
  parameter int unsigned ADDRW   = 10,
  parameter int unsigned CNTW    = 16,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic             clk_sys,
  input  logic             rst_sys,
  input  logic             frame,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic             cmd_cont,
  input  logic             cmd_stop,
  output logic             er_start,
  output logic [ADDRW-1:0] er_addr,
  input  logic             er_busy,
  input  logic             er_done,
  output logic             sts_busy,
  output logic [CNTW-1:0]  sts_runs,
  output logic [CNTW-1:0]  sts_overrun,
  output logic             sts_timeout
);

  localparam int unsigned    TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    START = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t        state, state_n;
  logic          cont;
  logic          stop_pend;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic          done_hit;
  logic          tmo_hit;

  // Engine busy is informational only; a run ends solely on er_done.
  logic unused_busy;
  assign unused_busy = er_busy;

  assign cmd_ready = (state == IDLE);
  assign sts_busy  = (state != IDLE);
  assign er_start  = (state == START);

  // Next-state and per-cycle event decode.
  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    done_hit = 1'b0;
    tmo_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (cont && cmd_stop) state_n = IDLE;
        else if (frame)       state_n = START;
      end
      START: state_n = RUN;
      RUN: begin
        // A done in the final counted cycle beats the timeout.
        if (er_done) begin
          done_hit = 1'b1;
          state_n  = (cont && !stop_pend && !cmd_stop) ? ARMED : IDLE;
        end else if (tcnt == TLAST) begin
          tmo_hit = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register, request latch, run timer and status counters.
  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state       <= IDLE;
      er_addr     <= '0;
      cont        <= 1'b0;
      stop_pend   <= 1'b0;
      tcnt        <= '0;
      sts_runs    <= '0;
      sts_overrun <= '0;
      sts_timeout <= 1'b0;
    end else begin
      state <= state_n;

      if (accept) begin
        er_addr <= cmd_addr;
        cont    <= cmd_cont;
      end

      if (state_n == IDLE) begin
        cont      <= 1'b0;
        stop_pend <= 1'b0;
      end else if ((state == START || state == RUN) && cmd_stop) begin
        stop_pend <= 1'b1;
      end

      if (state == START)    tcnt <= '0;
      else if (state == RUN) tcnt <= tcnt + 1'b1;

      if (done_hit && sts_runs != '1)
        sts_runs <= sts_runs + 1'b1;

      if (state == RUN && frame && sts_overrun != '1)
        sts_overrun <= sts_overrun + 1'b1;

      if (tmo_hit) sts_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_er_sched.sv
// Directed bench for er_sched: one-shot, continuous, overrun, timeout,
// boundary cases, mid-run reset and run-counter saturation.
module tb_er_sched;

  logic       clk_sys = 1'b0;
  logic       rst_sys = 1'b1;
  logic       frame = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_addr = '0;
  logic       cmd_cont = 1'b0;
  logic       cmd_stop = 1'b0;
  logic       er_start;
  logic [9:0] er_addr;
  logic       er_busy = 1'b0;
  logic       er_done = 1'b0;
  logic       sts_busy;
  logic [3:0] sts_runs;
  logic [3:0] sts_overrun;
  logic       sts_timeout;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int exp_runs = 0;
  int exp_ovr = 0;

  er_sched #(.ADDRW(10), .CNTW(4), .TIMEOUT(64)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .frame(frame),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_cont(cmd_cont), .cmd_stop(cmd_stop), .er_start(er_start),
    .er_addr(er_addr), .er_busy(er_busy), .er_done(er_done),
    .sts_busy(sts_busy), .sts_runs(sts_runs), .sts_overrun(sts_overrun),
    .sts_timeout(sts_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) if (er_start) start_cnt <= start_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_cmd(input logic [9:0] a, input logic c);
    cmd_valid = 1'b1; cmd_addr = a; cmd_cont = c;
    tick();
    cmd_valid = 1'b0; cmd_cont = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1; tick(); frame = 1'b0;
  endtask

  task automatic pulse_done();
    er_busy = 1'b0; er_done = 1'b1; tick(); er_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_sys = 1'b1; tick(); tick();
    rst_sys = 1'b0;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", cmd_ready); end
    checks++; if (er_start !== 1'b0) begin errors++; $display("FAIL rst_start got %b exp 0", er_start); end
    checks++; if (er_addr !== 10'h000) begin errors++; $display("FAIL rst_addr got %h exp 000", er_addr); end
    checks++; if (sts_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", sts_busy); end
    checks++; if (sts_runs !== 4'd0) begin errors++; $display("FAIL rst_runs got %0d exp 0", sts_runs); end
    checks++; if (sts_overrun !== 4'd0) begin errors++; $display("FAIL rst_ovr got %0d exp 0", sts_overrun); end
    checks++; if (sts_timeout !== 1'b0) begin errors++; $display("FAIL rst_tmo got %b exp 0", sts_timeout); end
    exp_runs = 0; exp_ovr = 0;
  endtask

  task automatic test_oneshot();
    send_cmd(10'h040, 1'b0);
    checks++; if (cmd_ready !== 1'b0 || sts_busy !== 1'b1) begin errors++; $display("FAIL os_armed got ready=%b busy=%b exp 0/1", cmd_ready, sts_busy); end
    repeat (8) tick();
    checks++; if (er_start !== 1'b0) begin errors++; $display("FAIL os_nostart got %b exp 0", er_start); end
    pulse_frame();
    checks++; if (er_start !== 1'b1 || er_addr !== 10'h040) begin errors++; $display("FAIL os_start got start=%b addr=%h exp 1/040", er_start, er_addr); end
    er_busy = 1'b1;
    tick();
    checks++; if (er_start !== 1'b0) begin errors++; $display("FAIL os_startpulse got %b exp 0", er_start); end
    repeat (37) tick();
    pulse_done(); exp_runs++;
    checks++; if (sts_runs !== 4'(exp_runs)) begin errors++; $display("FAIL os_runs got %0d exp %0d", sts_runs, exp_runs); end
    checks++; if (cmd_ready !== 1'b1 || sts_busy !== 1'b0) begin errors++; $display("FAIL os_idle got ready=%b busy=%b exp 1/0", cmd_ready, sts_busy); end
    checks++; if (er_addr !== 10'h040) begin errors++; $display("FAIL os_addr_hold got %h exp 040", er_addr); end
  endtask

  task automatic test_continuous();
    int s0;
    s0 = start_cnt;
    send_cmd(10'h123, 1'b1);
    for (int k = 0; k < 4; k++) begin
      repeat (3) tick();
      pulse_frame();
      checks++; if (er_start !== 1'b1 || er_addr !== 10'h123) begin errors++; $display("FAIL ct_start%0d got start=%b addr=%h exp 1/123", k, er_start, er_addr); end
      tick();
      repeat (10) tick();
      if (k == 3) begin
        cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
        repeat (3) tick();
      end
      pulse_done(); exp_runs++;
      checks++; if (sts_runs !== 4'(exp_runs)) begin errors++; $display("FAIL ct_runs%0d got %0d exp %0d", k, sts_runs, exp_runs); end
      if (k < 3) begin
        checks++; if (sts_busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL ct_rearm%0d got busy=%b ready=%b exp 1/0", k, sts_busy, cmd_ready); end
      end else begin
        checks++; if (sts_busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL ct_stop got busy=%b ready=%b exp 0/1", sts_busy, cmd_ready); end
      end
    end
    pulse_frame();
    checks++; if (er_start !== 1'b0) begin errors++; $display("FAIL ct_no5th got %b exp 0", er_start); end
    tick();
    checks++; if (start_cnt - s0 !== 4) begin errors++; $display("FAIL ct_starts got %0d exp 4", start_cnt - s0); end
    checks++; if (sts_overrun !== 4'(exp_ovr)) begin errors++; $display("FAIL ct_ovr got %0d exp %0d", sts_overrun, exp_ovr); end
  endtask

  task automatic test_overrun();
    send_cmd(10'h200, 1'b1);
    tick();
    pulse_frame();
    checks++; if (er_start !== 1'b1) begin errors++; $display("FAIL ov_start1 got %b exp 1", er_start); end
    tick(); repeat (5) tick();
    pulse_frame(); exp_ovr++;
    checks++; if (sts_overrun !== 4'(exp_ovr) || sts_busy !== 1'b1) begin errors++; $display("FAIL ov_late got ovr=%0d busy=%b exp %0d/1", sts_overrun, sts_busy, exp_ovr); end
    repeat (5) tick();
    pulse_done(); exp_runs++;
    checks++; if (er_start !== 1'b0 || sts_busy !== 1'b1) begin errors++; $display("FAIL ov_wait got start=%b busy=%b exp 0/1", er_start, sts_busy); end
    repeat (2) tick();
    checks++; if (er_start !== 1'b0) begin errors++; $display("FAIL ov_nostart got %b exp 0", er_start); end
    pulse_frame();
    checks++; if (er_start !== 1'b1) begin errors++; $display("FAIL ov_start2 got %b exp 1", er_start); end
    tick(); repeat (3) tick();
    er_done = 1'b1; frame = 1'b1; tick(); er_done = 1'b0; frame = 1'b0;
    exp_ovr++; exp_runs++;
    checks++; if (sts_overrun !== 4'(exp_ovr) || sts_runs !== 4'(exp_runs)) begin errors++; $display("FAIL ov_same got ovr=%0d runs=%0d exp %0d/%0d", sts_overrun, sts_runs, exp_ovr, exp_runs); end
    checks++; if (er_start !== 1'b0 || sts_busy !== 1'b1) begin errors++; $display("FAIL ov_same_arm got start=%b busy=%b exp 0/1", er_start, sts_busy); end
    tick();
    checks++; if (er_start !== 1'b0) begin errors++; $display("FAIL ov_same_nostart got %b exp 0", er_start); end
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    checks++; if (sts_busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL arm_stop got busy=%b ready=%b exp 0/1", sts_busy, cmd_ready); end
    pulse_frame();
    checks++; if (er_start !== 1'b0) begin errors++; $display("FAIL arm_stop_nostart got %b exp 0", er_start); end
  endtask

  task automatic test_done_vs_timeout();
    send_cmd(10'h155, 1'b0);
    pulse_frame();
    repeat (64) tick();
    checks++; if (sts_busy !== 1'b1 || sts_timeout !== 1'b0) begin errors++; $display("FAIL dvt_pre got busy=%b tmo=%b exp 1/0", sts_busy, sts_timeout); end
    pulse_done(); exp_runs++;
    checks++; if (sts_runs !== 4'(exp_runs) || sts_timeout !== 1'b0 || sts_busy !== 1'b0) begin errors++; $display("FAIL dvt_done got runs=%0d tmo=%b busy=%b exp %0d/0/0", sts_runs, sts_timeout, sts_busy, exp_runs); end
  endtask

  task automatic test_timeout();
    send_cmd(10'h0AA, 1'b0);
    pulse_frame();
    checks++; if (er_start !== 1'b1) begin errors++; $display("FAIL to_start got %b exp 1", er_start); end
    repeat (64) tick();
    checks++; if (sts_busy !== 1'b1 || sts_timeout !== 1'b0) begin errors++; $display("FAIL to_pre got busy=%b tmo=%b exp 1/0", sts_busy, sts_timeout); end
    tick();
    checks++; if (sts_timeout !== 1'b1 || sts_busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL to_hit got tmo=%b busy=%b ready=%b exp 1/0/1", sts_timeout, sts_busy, cmd_ready); end
    checks++; if (sts_runs !== 4'(exp_runs)) begin errors++; $display("FAIL to_runs got %0d exp %0d", sts_runs, exp_runs); end
    pulse_done();
    checks++; if (sts_runs !== 4'(exp_runs) || sts_timeout !== 1'b1) begin errors++; $display("FAIL to_late_done got runs=%0d tmo=%b exp %0d/1", sts_runs, sts_timeout, exp_runs); end
  endtask

  task automatic test_boundaries();
    cmd_valid = 1'b1; cmd_addr = 10'h0F0; cmd_cont = 1'b0; frame = 1'b1;
    tick();
    cmd_valid = 1'b0; frame = 1'b0;
    checks++; if (er_start !== 1'b0 || sts_busy !== 1'b1) begin errors++; $display("FAIL bd_coinc got start=%b busy=%b exp 0/1", er_start, sts_busy); end
    tick();
    checks++; if (er_start !== 1'b0) begin errors++; $display("FAIL bd_coinc2 got %b exp 0", er_start); end
    pulse_frame();
    checks++; if (er_start !== 1'b1 || er_addr !== 10'h0F0) begin errors++; $display("FAIL bd_start got start=%b addr=%h exp 1/0F0", er_start, er_addr); end
    tick();
    cmd_valid = 1'b1; cmd_addr = 10'h3FF; tick(); cmd_valid = 1'b0;
    checks++; if (er_addr !== 10'h0F0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL bd_notready got addr=%h ready=%b exp 0F0/0", er_addr, cmd_ready); end
    pulse_done(); exp_runs++;
    checks++; if (er_addr !== 10'h0F0 || sts_runs !== 4'(exp_runs)) begin errors++; $display("FAIL bd_after got addr=%h runs=%0d exp 0F0/%0d", er_addr, sts_runs, exp_runs); end
  endtask

  task automatic test_reset_mid_run();
    send_cmd(10'h321, 1'b1);
    pulse_frame(); tick(); repeat (4) tick();
    rst_sys = 1'b1; tick();
    checks++; if (sts_busy !== 1'b0 || cmd_ready !== 1'b1 || er_start !== 1'b0 || er_addr !== 10'h000) begin errors++; $display("FAIL mr_rst got busy=%b ready=%b start=%b addr=%h exp 0/1/0/000", sts_busy, cmd_ready, er_start, er_addr); end
    checks++; if (sts_runs !== 4'd0 || sts_overrun !== 4'd0 || sts_timeout !== 1'b0) begin errors++; $display("FAIL mr_sts got runs=%0d ovr=%0d tmo=%b exp 0/0/0", sts_runs, sts_overrun, sts_timeout); end
    rst_sys = 1'b0; exp_runs = 0; exp_ovr = 0;
    tick();
    checks++; if (er_start !== 1'b0) begin errors++; $display("FAIL mr_post got %b exp 0", er_start); end
    send_cmd(10'h077, 1'b0);
    pulse_frame();
    checks++; if (er_start !== 1'b1 || er_addr !== 10'h077) begin errors++; $display("FAIL mr_new got start=%b addr=%h exp 1/077", er_start, er_addr); end
    tick(); pulse_done(); exp_runs++;
    checks++; if (sts_runs !== 4'(exp_runs) || sts_busy !== 1'b0) begin errors++; $display("FAIL mr_done got runs=%0d busy=%b exp %0d/0", sts_runs, sts_busy, exp_runs); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) begin
      send_cmd(10'(i), 1'b0);
      pulse_frame(); tick(); pulse_done();
      exp_runs = (exp_runs >= 15) ? 15 : exp_runs + 1;
      checks++; if (sts_runs !== 4'(exp_runs)) begin errors++; $display("FAIL sat_runs%0d got %0d exp %0d", i, sts_runs, exp_runs); end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_continuous();
    test_overrun();
    test_done_vs_timeout();
    test_timeout();
    test_boundaries();
    test_reset_mid_run();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
